// File: rtl/cache_mem_arbiter.sv
// Shares the pmem line port between I-cache and D-cache (D has priority).
// Optional I-cache anti-starvation: define CACHE_ARB_ANTI_STARVE_EN.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [1:0]            arb_owner
);

  typedef enum logic [1:0] {
    IDLE, SERVE_I, SERVE_D, RECOVER
  } state_t;

  state_t                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  d_req;
  logic                  force_i;
  logic                  grant_d;
  logic                  grant_i;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant_d = (state_q == IDLE) & d_req & ~force_i;
  assign grant_i = (state_q == IDLE) & i_pmem_read & ~grant_d;

`ifdef CACHE_ARB_ANTI_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign force_i = i_pmem_read & (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (grant_i)
      starve_d = '0;
    else if (grant_d && i_pmem_read && starve_q != LIMIT)
      starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Command fields come only from the latches so they hold until pmem_resp.
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    arb_owner   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          op_wr_d = d_pmem_write;
          addr_d  = d_pmem_address;
          wdata_d = d_pmem_wdata;
          state_d = SERVE_D;
        end else if (grant_i) begin
          op_wr_d = 1'b0;
          addr_d  = i_pmem_address;
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read   = ~op_wr_q;
        pmem_write  = op_wr_q;
        arb_owner   = 2'b01;
        i_pmem_resp = pmem_resp;
        if (pmem_resp) state_d = RECOVER;
      end
      SERVE_D: begin
        pmem_read   = ~op_wr_q;
        pmem_write  = op_wr_q;
        arb_owner   = 2'b10;
        d_pmem_resp = pmem_resp;
        if (pmem_resp) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst)
    !(d_pmem_read && d_pmem_write));

  a_cmd_excl: assert property (@(posedge clk)
    !(pmem_read && pmem_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter.
// Honours CACHE_ARB_ANTI_STARVE_EN in the starvation scenario.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   arb_owner;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_WIDTH(32),
    .LINE_WIDTH(256),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_pmem_read(i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata),
    .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata),
    .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .arb_owner(arb_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [255:0] line;
    line = {32{8'h3C}};
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00)
      $display("FAIL rst_cmd got=%b exp=00",
               {pmem_read, pmem_write});
    else passed++;
    total++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b00)
      $display("FAIL rst_resp got=%b exp=00",
               {i_pmem_resp, d_pmem_resp});
    else passed++;
    total++;
    if (arb_owner !== 2'b00)
      $display("FAIL rst_owner got=%b exp=00", arb_owner);
    else passed++;
    pmem_rdata = line;
    settle();
    total++;
    if (i_pmem_rdata !== line || d_pmem_rdata !== line)
      $display("FAIL rdata_follow got=%h exp=%h",
               i_pmem_rdata, line);
    else passed++;
    rst = 1'b1;
    tick();
    pmem_resp = 1'b1;
    settle();
    total++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b00)
      $display("FAIL idle_stray_resp got=%b exp=00",
               {i_pmem_resp, d_pmem_resp});
    else passed++;
    tick();
    pmem_resp = 1'b0;
    total++;
    if (arb_owner !== 2'b00)
      $display("FAIL idle_owner got=%b exp=00", arb_owner);
    else passed++;
  endtask

  task automatic test_i_only();
    logic [255:0] line;
    line = {32{8'hA5}};
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_0060;
    settle();
    total++;
    if (pmem_read !== 1'b0)
      $display("FAIL i_cmd_before_grant got=%b exp=0", pmem_read);
    else passed++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 5) begin
        pmem_rdata = line;
        pmem_resp = 1'b1;
        settle();
      end
      total++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 ||
          pmem_address !== 32'h60 || arb_owner !== 2'b01)
        $display("FAIL i_serve c=%0d got=%b%b %h %b exp=10 60 01",
                 c, pmem_read, pmem_write, pmem_address, arb_owner);
      else passed++;
      total++;
      if (i_pmem_resp !== (c == 5) || d_pmem_resp !== 1'b0)
        $display("FAIL i_resp c=%0d got=%b%b exp=%b0",
                 c, i_pmem_resp, d_pmem_resp, (c == 5));
      else passed++;
    end
    total++;
    if (i_pmem_rdata !== line)
      $display("FAIL i_rdata got=%h exp=%h", i_pmem_rdata, line);
    else passed++;
    tick();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    settle();
    total++;
    if (pmem_read !== 1'b0 || arb_owner !== 2'b00 ||
        i_pmem_resp !== 1'b0)
      $display("FAIL i_recover got=%b %b %b exp=0 00 0",
               pmem_read, arb_owner, i_pmem_resp);
    else passed++;
    tick();
  endtask

  task automatic test_same_cycle();
    logic [255:0] wl;
    wl = {8{32'hDEAD_BEEF}};
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_0400;
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_1000;
    d_pmem_wdata = wl;
    tick();
    total++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 ||
        pmem_address !== 32'h1000 || arb_owner !== 2'b10)
      $display("FAIL d_first got=%b%b %h %b exp=01 1000 10",
               pmem_read, pmem_write, pmem_address, arb_owner);
    else passed++;
    total++;
    if (pmem_wdata !== wl)
      $display("FAIL d_wdata got=%h exp=%h", pmem_wdata, wl);
    else passed++;
    pmem_resp = 1'b1;
    settle();
    total++;
    if ({d_pmem_resp, i_pmem_resp} !== 2'b10)
      $display("FAIL d_resp got=%b exp=10",
               {d_pmem_resp, i_pmem_resp});
    else passed++;
    tick();
    pmem_resp = 1'b0;
    d_pmem_write = 1'b0;
    settle();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00 || arb_owner !== 2'b00)
      $display("FAIL recover_gap got=%b%b %b exp=00 00",
               pmem_read, pmem_write, arb_owner);
    else passed++;
    tick();
    total++;
    if (pmem_read !== 1'b0)
      $display("FAIL idle_gap got=%b exp=0", pmem_read);
    else passed++;
    tick();
    total++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h400 ||
        arb_owner !== 2'b01)
      $display("FAIL i_after_d got=%b %h %b exp=1 400 01",
               pmem_read, pmem_address, arb_owner);
    else passed++;
    pmem_resp = 1'b1;
    settle();
    total++;
    if ({d_pmem_resp, i_pmem_resp} !== 2'b01)
      $display("FAIL i_resp2 got=%b exp=01",
               {d_pmem_resp, i_pmem_resp});
    else passed++;
    tick();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_d_blocks_i();
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_2000;
    tick();
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      settle();
      total++;
      if (pmem_address !== 32'h2000 || arb_owner !== 2'b10 ||
          pmem_read !== 1'b1)
        $display("FAIL d_hold k=%0d got=%h %b %b exp=2000 10 1",
                 k, pmem_address, arb_owner, pmem_read);
      else passed++;
      if (k == 1) d_pmem_address = 32'h0BAD_0000;
      tick();
    end
    pmem_resp = 1'b1;
    settle();
    total++;
    if ({d_pmem_resp, i_pmem_resp} !== 2'b10 ||
        pmem_address !== 32'h2000)
      $display("FAIL d_done got=%b %h exp=10 2000",
               {d_pmem_resp, i_pmem_resp}, pmem_address);
    else passed++;
    tick();
    pmem_resp = 1'b0;
    d_pmem_read = 1'b0;
    i_pmem_read = 1'b0;
    tick();
    tick();
    total++;
    if (arb_owner !== 2'b00 || i_pmem_resp !== 1'b0)
      $display("FAIL dropped_i got=%b %b exp=00 0",
               arb_owner, i_pmem_resp);
    else passed++;
  endtask

  task automatic test_starve();
    logic [1:0] exp_own [6];
    int n;
`ifdef CACHE_ARB_ANTI_STARVE_EN
    exp_own = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
    exp_own = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
    apply_reset();
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_5000;
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_6000;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (arb_owner == 2'b00 && n < 10) begin
        tick();
        n++;
      end
      total++;
      if (arb_owner !== exp_own[g])
        $display("FAIL starve_grant g=%0d got=%b exp=%b",
                 g, arb_owner, exp_own[g]);
      else passed++;
      pmem_resp = 1'b1;
      settle();
      total++;
      if ({d_pmem_resp, i_pmem_resp} !== exp_own[g])
        $display("FAIL starve_resp g=%0d got=%b exp=%b",
                 g, {d_pmem_resp, i_pmem_resp}, exp_own[g]);
      else passed++;
      tick();
      pmem_resp = 1'b0;
    end
    d_pmem_read = 1'b0;
    n = 0;
    while (arb_owner == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (arb_owner !== 2'b01 || pmem_address !== 32'h6000)
      $display("FAIL i_after_d_idle got=%b %h exp=01 6000",
               arb_owner, pmem_address);
    else passed++;
    pmem_resp = 1'b1;
    settle();
    tick();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_7000;
    tick();
    total++;
    if (pmem_write !== 1'b1 || arb_owner !== 2'b10)
      $display("FAIL mid_serve got=%b %b exp=1 10",
               pmem_write, arb_owner);
    else passed++;
    rst = 1'b0;
    d_pmem_write = 1'b0;
    tick();
    total++;
    if ({pmem_read, pmem_write} !== 2'b00 || arb_owner !== 2'b00)
      $display("FAIL mid_rst got=%b%b %b exp=00 00",
               pmem_read, pmem_write, arb_owner);
    else passed++;
    rst = 1'b1;
    tick();
    pmem_resp = 1'b1;
    settle();
    total++;
    if ({d_pmem_resp, i_pmem_resp} !== 2'b00)
      $display("FAIL post_rst_stray got=%b exp=00",
               {d_pmem_resp, i_pmem_resp});
    else passed++;
    tick();
    pmem_resp = 1'b0;
    total++;
    if (arb_owner !== 2'b00)
      $display("FAIL post_rst_owner got=%b exp=00", arb_owner);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_same_cycle();
    test_d_blocks_i();
    test_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory (pmem) line port between the I-cache and the D-cache miss/writeback paths.
- Sits between both caches and the burst/pmem adapter.
- Its grant and response timing directly drive `instr_mem_resp` / `data_mem_resp` stalls in the pipeline.
- Fixed D-cache priority, one outstanding transaction, registered grant, one recovery cycle after each completion.

Parameters:
- ADDR_WIDTH, 32, byte address width of all address ports
- LINE_WIDTH, 256, cache line width in bits
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset; rst==0 at a rising clk edge resets the block
- i_pmem_read  in  1  I-cache line fill request; held until i_pmem_resp
- i_pmem_address  in  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line fill request; held until d_pmem_resp
- d_pmem_write  in  1  D-cache writeback request; held until d_pmem_resp
- d_pmem_address  in  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  in  LINE_WIDTH  writeback line
- d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write data
- pmem_rdata  in  LINE_WIDTH  memory read data
- pmem_resp  in  1  memory completion pulse
- arb_owner  out  2  00 none, 01 I-cache, 10 D-cache (debug/perf)

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- Reset (rst==0): state IDLE; address/wdata/op latches cleared to 0; starve counter 0.
  - All outputs 0: pmem_read, pmem_write, both resp, arb_owner.
  - All rdata outputs follow pmem_rdata; they are don't-care unless resp=1.
- IDLE: requests sampled at the clock edge.
  - Any D request (read or write) pending: latch d_pmem_address, d_pmem_wdata, and op (write if d_pmem_write), then go to SERVE_D.
  - Else if i_pmem_read: latch i_pmem_address, op=read, then go to SERVE_I.
  - Else stay in IDLE.
  - No pmem command is driven in IDLE.
- Latency: request seen at edge N, so pmem_read/pmem_write are high from cycle N+1. Minimum is one cycle from request to command.
- SERVE_x:
  - pmem_read/pmem_write come from the latched op; pmem_address/pmem_wdata come from the latches. All are held stable until pmem_resp.
  - arb_owner = 01 or 10.
  - On pmem_resp: assert x_pmem_resp in the same cycle (combinational pass-through), x_pmem_rdata = pmem_rdata, go to RECOVER.
  - Never assert the other requester's resp.
- RECOVER: exactly one cycle with all commands and resp low and no grant, then IDLE.
  - Guarantees the completed cache has deasserted its request before resampling.
  - Back-to-back transactions are therefore spaced at least 2 cycles apart from resp to the next command.
- Requester changes: address/wdata changes while in SERVE are ignored because the latches hold.
  - A request that drops before grant is lost silently; no resp is issued.
- d_pmem_read and d_pmem_write both high: write wins. This condition is illegal from the D-cache and is covered by an assertion.
- pmem_resp while in IDLE or RECOVER: ignored, no resp forwarded.
- Reset mid-transaction: return to IDLE immediately and drop commands. The outstanding memory transaction is abandoned, and the memory model must also be reset.
- Only one transaction is outstanding at a time; the block never asserts pmem_read and pmem_write together.

Optional Feature:
- Macro CACHE_ARB_ANTI_STARVE_EN.
- Defined:
  - A ceil(log2(STARVE_LIMIT+1))-bit counter increments on each D grant made while i_pmem_read is high, and clears on every I grant.
  - When the counter equals STARVE_LIMIT and i_pmem_read is high in IDLE, I is granted even if D is pending.
- Undefined: counter absent; strict D priority at all times.

Test Plan:
- I-only read at 0x0000_0060, memory replies after 5 cycles with line 0xA5.. -> pmem_read high cycles 1-5 at 0x60, i_pmem_resp single pulse on cycle 5 carrying the line, arb_owner 01 then 00, d_pmem_resp never high.
- I read and D write of 0x1000 asserted in the same cycle -> D serviced first (pmem_write, wdata matches), one RECOVER cycle, then I read issued; each cache sees exactly one resp.
- D read in flight while I requests for 3 cycles, with 0x2000 on the D address bus -> I address never appears on pmem_address until D completes.
- Continuous D traffic with I pending, macro defined, STARVE_LIMIT=4 -> I granted after 4th D completion; macro undefined -> I waits until D idle.
- rst driven to 0 during SERVE_D -> next cycle pmem_read/pmem_write=0, arb_owner=00; stray pmem_resp afterwards produces no cache resp.
